// File: rtl/flag_stack_if.sv
// flag_stack_if: control-unit bus for the status-flag register and its shadow stack.
interface flag_stack_if #(
    parameter int NUM_FLAGS   = 2,
    parameter int STACK_DEPTH = 4
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    logic [NUM_FLAGS-1:0] flg_clr, flg_ld, flg_set, flg_in, flags;
    logic                 flg_push, flg_pop, err_clr;
    logic [DW-1:0]        depth;
    logic                 stk_empty, stk_full, stk_ovf, stk_unf;
    modport master (
        output flg_clr, flg_ld, flg_set, flg_in, flg_push, flg_pop, err_clr,
        input  flags, depth, stk_empty, stk_full, stk_ovf, stk_unf
    );
    modport slave (
        input  flg_clr, flg_ld, flg_set, flg_in, flg_push, flg_pop, err_clr,
        output flags, depth, stk_empty, stk_full, stk_ovf, stk_unf
    );
endinterface

// File: rtl/flag_stack.sv
// flag_stack: live status flags with a LIFO shadow stack for nested interrupts.
module flag_stack #(
    parameter int                   NUM_FLAGS   = 2,
    parameter int                   STACK_DEPTH = 4,
    parameter logic [NUM_FLAGS-1:0] RESET_FLAGS = '0
) (
    input logic         clk_i,
    input logic         rst_i,
    flag_stack_if.slave bus
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int AW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    logic [NUM_FLAGS-1:0] flags_q, flags_d, upd;
    logic [NUM_FLAGS-1:0] stack_q [STACK_DEPTH];
    logic [DW-1:0]        depth_q, depth_d;
    logic [AW-1:0]        top, wr_idx;
    logic                 ovf_q, ovf_d, unf_q, unf_d, empty, full, do_push, do_pop, swap;
    always_comb begin
        empty   = depth_q == '0;
        full    = depth_q == DW'(STACK_DEPTH);
        do_pop  = bus.flg_pop & ~empty;
        swap    = do_pop & bus.flg_push;
        do_push = bus.flg_push & ~bus.flg_pop & ~full;
        top     = AW'(depth_q - DW'(1));
        wr_idx  = swap ? top : AW'(depth_q);
        // clear beats load beats set
        upd     = (((flags_q | bus.flg_set) & ~bus.flg_ld) | (bus.flg_in & bus.flg_ld)) & ~bus.flg_clr;
        flags_d = do_pop ? stack_q[top] : upd;
        depth_d = do_push ? depth_q + DW'(1) : (do_pop & ~swap) ? depth_q - DW'(1) : depth_q;
        ovf_d   = (bus.flg_push & ~bus.flg_pop & full) | (ovf_q & ~bus.err_clr);
        unf_d   = (bus.flg_pop & empty) | (unf_q & ~bus.err_clr);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags_q <= RESET_FLAGS;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i && (do_push || swap)) stack_q[wr_idx] <= flags_q;
    end
    assign bus.flags     = flags_q;
    assign bus.depth     = depth_q;
    assign bus.stk_empty = empty;
    assign bus.stk_full  = full;
    assign bus.stk_ovf   = ovf_q;
    assign bus.stk_unf   = unf_q;
endmodule

// File: tb/tb_flag_stack.sv
// tb_flag_stack: directed test-plan cases plus random traffic against a queue-based model.
module tb_flag_stack;
    localparam int NF = 2;
    localparam int SD = 4;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [NF-1:0] m_flags = '0;
    logic [NF-1:0] stk[$];
    bit   m_ovf = 0, m_unf = 0;
    flag_stack_if #(.NUM_FLAGS(NF), .STACK_DEPTH(SD)) bus ();
    flag_stack #(.NUM_FLAGS(NF), .STACK_DEPTH(SD), .RESET_FLAGS(2'b00)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask
    task automatic model(input bit r, input logic [NF-1:0] c, l, s, d, input bit pu, po, e);
        logic [NF-1:0] nf;
        bit em, fu;
        if (r) begin
            m_flags = '0;
            stk.delete();
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        em = stk.size() == 0;
        fu = stk.size() == SD;
        for (int i = 0; i < NF; i++)
            nf[i] = c[i] ? 1'b0 : l[i] ? d[i] : s[i] ? 1'b1 : m_flags[i];
        if (po && !em) begin
            nf = stk[$];
            if (pu) stk[$] = m_flags;
            else void'(stk.pop_back());
        end else if (pu && !po && !fu) stk.push_back(m_flags);
        m_ovf = (pu && !po && fu) || (m_ovf && !e);
        m_unf = (po && em) || (m_unf && !e);
        m_flags = nf;
    endtask
    task automatic cyc(input bit r, input logic [NF-1:0] c, l, s, d, input bit pu, po, e);
        rst_i = r; bus.flg_clr = c; bus.flg_ld = l; bus.flg_set = s; bus.flg_in = d;
        bus.flg_push = pu; bus.flg_pop = po; bus.err_clr = e;
        @(posedge clk_i);
        model(r, c, l, s, d, pu, po, e);
        #1;
        chk("flags", 32'(bus.flags), 32'(m_flags));
        chk("depth", 32'(bus.depth), stk.size());
        chk("empty", 32'(bus.stk_empty), 32'(stk.size() == 0));
        chk("full",  32'(bus.stk_full), 32'(stk.size() == SD));
        chk("ovf",   32'(bus.stk_ovf), 32'(m_ovf));
        chk("unf",   32'(bus.stk_unf), 32'(m_unf));
    endtask
    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_flags", 32'(bus.flags), 0);
        chk("rst_empty", 32'(bus.stk_empty), 1);
        cyc(0, 2'b01, 2'b11, 2'b11, 2'b10, 0, 0, 0);
        chk("prio", 32'(bus.flags), 32'h2);
        cyc(0, 0, 0, 2'b01, 0, 0, 0, 0);
        chk("set_c", 32'(bus.flags), 32'h3);
        cyc(0, 2'b10, 0, 2'b01, 0, 0, 0, 0);
        cyc(0, 0, 2'b11, 0, 2'b10, 1, 0, 0);
        chk("nest_push", 32'(bus.flags), 32'h2);
        chk("nest_depth", 32'(bus.depth), 1);
        cyc(0, 0, 0, 2'b11, 0, 0, 1, 0);
        chk("nest_pop", 32'(bus.flags), 32'h1);
        cyc(0, 2'b11, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 0, i < 4 ? 2'b11 : 2'b00, 0, 2'(i), 1, 0, 0);
        chk("full4", 32'(bus.stk_full), 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("ovf", 32'(bus.stk_ovf), 1);
        for (int i = 3; i >= 0; i--) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
            chk("pop_seq", 32'(bus.flags), i);
        end
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("unf", 32'(bus.stk_unf), 1);
        chk("unf_hold", 32'(bus.flags), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("errclr", 32'({bus.stk_ovf, bus.stk_unf}), 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        chk("err_wins", 32'(bus.stk_unf), 1);
        cyc(0, 0, 2'b11, 0, 2'b10, 0, 0, 1);
        cyc(0, 0, 2'b11, 0, 2'b01, 1, 0, 0);
        cyc(0, 0, 2'b11, 2'b11, 0, 1, 1, 0);
        chk("swap", 32'(bus.flags), 32'h2);
        chk("swap_depth", 32'(bus.depth), 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("swap_pop", 32'(bus.flags), 32'h1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 2'b01, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 0, 0);
        chk("rst_mid_depth", 32'(bus.depth), 0);
        chk("rst_mid_flags", 32'(bus.flags), 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("rst_mid_unf", 32'(bus.stk_unf), 1);
        for (int k = 0; k < 3000; k++)
            cyc($urandom_range(99) < 2, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                $urandom_range(99) < 35, $urandom_range(99) < 35, $urandom_range(99) < 10);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/flag_stack.md
# flag_stack

Parametrised processor status-flag register with a LIFO shadow stack for nested interrupts. It holds NUM_FLAGS live flags (bit 0 = C, bit 1 = Z in the default build), each with independent clear/load/set control from the control unit. On interrupt entry it saves the live flags; on return-from-interrupt it restores them, up to STACK_DEPTH nesting levels. It sits between the ALU flag outputs and the control unit / branch logic, and it replaces the single-level shadow-flag scheme.

## Interface
- NUM_FLAGS, 2, number of flag bits (≥1); bit 0 = C, bit 1 = Z.
- STACK_DEPTH, 4, number of shadow entries (≥1).
- RESET_FLAGS, '0, NUM_FLAGS-bit value loaded into FLAGS on reset.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset; synchronous, active-high.
- FLG_CLR  in  NUM_FLAGS  per-flag clear.
- FLG_LD  in  NUM_FLAGS  per-flag load from FLG_IN.
- FLG_SET  in  NUM_FLAGS  per-flag set.
- FLG_IN  in  NUM_FLAGS  ALU flag values.
- FLG_PUSH  in  1  save FLAGS to stack (interrupt entry).
- FLG_POP  in  1  restore FLAGS from stack (interrupt return).
- ERR_CLR  in  1  clear sticky error bits.
- FLAGS  out  NUM_FLAGS  live flags, registered.
- DEPTH  out  $clog2(STACK_DEPTH+1)  occupied entries, 0..STACK_DEPTH.
- STK_EMPTY  out  1  DEPTH == 0.
- STK_FULL  out  1  DEPTH == STACK_DEPTH.
- STK_OVF  out  1  sticky: push attempted while full.
- STK_UNF  out  1  sticky: pop attempted while empty.

## Operation
- Per-flag update, bit i, when not overridden by a pop: FLG_CLR[i] → 0; else FLG_LD[i] → FLG_IN[i]; else FLG_SET[i] → 1; else hold.
- Push (not full, POP low): entry[DEPTH] ← FLAGS as registered before the edge, and DEPTH increments. Per-flag updates still apply to FLAGS in the same cycle.
- Pop (not empty, PUSH low): FLAGS ← entry[DEPTH-1] for all bits, and DEPTH decrements. A pop overrides FLG_CLR, FLG_LD and FLG_SET in that cycle.
- Push and pop together, not empty: swap. FLAGS ← top entry, top entry ← pre-edge FLAGS, DEPTH unchanged, per-flag controls ignored.
- Push while full: the entry is dropped, DEPTH and stack are unchanged, STK_OVF ← 1, and per-flag updates apply normally.
- Pop while empty (with or without push): stack is unchanged, STK_UNF ← 1, and per-flag updates apply normally. A simultaneous push is also dropped.
- STK_OVF and STK_UNF stay high until RST or ERR_CLR. If ERR_CLR coincides with a new error event, the error wins and the bit reads 1.
- Stack entries are never readable except through a pop. Unpopped contents are don't-care after reset.
- STK_EMPTY and STK_FULL are decoded from the DEPTH register and carry no extra latency.

## Timing
- Reset, synchronous, evaluated at a CLK edge with RST=1: FLAGS=RESET_FLAGS, DEPTH=0, STK_EMPTY=1, STK_FULL=0, STK_OVF=0, STK_UNF=0. RST overrides every other input.
- Reset mid-nesting discards all stacked entries. A pop on the next cycle is an underflow.
- All outputs are registered or decoded from registers. A request sampled at edge k is visible after edge k and stable for cycle k+1.
- Pop latency is one cycle: FLAGS shows the restored value in the cycle after FLG_POP.
- Back-to-back push/pop on consecutive cycles is fully supported with no bubble.
- No combinational path from any input to any output.

## Test plan
- Reset and flag priority, NUM_FLAGS=2, RESET_FLAGS=2'b00: RST → FLAGS=00, DEPTH=0, EMPTY=1. Then CLR=01, LD=11, SET=11, FLG_IN=10 → FLAGS=10 (C cleared, Z loaded). Then SET=01 only → FLAGS=11.
- Single nest: FLAGS=01, PUSH with LD=11 and FLG_IN=10 → FLAGS=10, DEPTH=1. Then POP with SET=11 → FLAGS=01, DEPTH=0, EMPTY=1.
- Full-depth nest, STACK_DEPTH=4:
  - Push FLAGS values 00, 01, 10, 11 in turn → DEPTH=4, FULL=1.
  - Fifth push → STK_OVF=1, DEPTH=4.
  - Four pops → FLAGS=11, 10, 01, 00 in order.
  - Fifth pop → STK_UNF=1, FLAGS unchanged.
- Swap: DEPTH=1 holding 10, FLAGS=01, PUSH+POP together → FLAGS=10, DEPTH=1. A following POP → FLAGS=01.
- Errors: ERR_CLR alone → OVF=UNF=0. ERR_CLR with a pop while empty → UNF=1.
- Reset mid-nest: DEPTH=3, RST with PUSH=1 → DEPTH=0, FLAGS=RESET_FLAGS, no entry stored. A following POP → UNF=1.
